seq_divider_unsigned: RTL and testbench



---
 rtl/seq_divider_unsigned.sv | 118 +++++++++++
 tb/tb_seq_divider_unsigned.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_unsigned.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock with one WIDTH+1-bit subtractor.
// Latency WIDTH cycles (1 for zero divisor); results hold in DONE until res_ready, start_ready only in IDLE.
module seq_divider_unsigned #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_sh;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             bit_ok;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH:0]   r_nxt;
  logic             d_zero;
  logic             last_iter;
  logic             accept;
  logic             unused_r_msb;

  // The partial remainder stays below the divisor, so its top bit never feeds the next shift.
  assign unused_r_msb = r_sh[WIDTH];

  assign shifted   = {r_sh[WIDTH-1:0], q_sh[WIDTH-1]};
  assign trial     = shifted - {1'b0, d_reg};
  assign bit_ok    = ~trial[WIDTH];
  assign q_nxt     = {q_sh[WIDTH-2:0], bit_ok};
  assign r_nxt     = bit_ok ? trial : shifted;
  assign d_zero    = (d_reg == '0);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign accept    = (state == IDLE) && start_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_valid) state_nxt = CALC;
      // A zero divisor spends exactly one cycle in CALC so its result lands one edge after accept.
      CALC: if (d_zero || last_iter) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state == IDLE);
    res_valid   = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sh  <= '0;
      d_reg <= '0;
      r_sh  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      q_sh  <= dividend;
      d_reg <= divisor;
      r_sh  <= '0;
      cnt   <= '0;
    end else if ((state == CALC) && !d_zero) begin
      q_sh  <= q_nxt;
      r_sh  <= r_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers load only on the edge entering DONE and otherwise keep the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == CALC) begin
      if (d_zero) begin
        quotient    <= '1;
        remainder   <= q_sh;
        div_by_zero <= 1'b1;
      end else if (last_iter) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_unsigned.sv
// Bench for seq_divider_unsigned: WIDTH=8 and WIDTH=13 instances checked every cycle
// against a cycle-level behavioural model built on plain / and % arithmetic.
module tb_seq_divider_unsigned;

  logic clk;
  int   checks;
  int   errors;
  logic done8;
  logic done13;

  logic        rst8, sv8, sr8, rv8, rr8, z8;
  logic [7:0]  dd8, ds8, q8, r8;
  logic        rst13, sv13, sr13, rv13, rr13, z13;
  logic [12:0] dd13, ds13, q13, r13;

  seq_divider_unsigned #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start_valid(sv8), .start_ready(sr8),
    .dividend(dd8), .divisor(ds8), .res_valid(rv8), .res_ready(rr8),
    .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  seq_divider_unsigned #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst13), .start_valid(sv13), .start_ready(sr13),
    .dividend(dd13), .divisor(ds13), .res_valid(rv13), .res_ready(rr13),
    .quotient(q13), .remainder(r13), .div_by_zero(z13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: busy from accept until the response handshake, result appears after a countdown.
  logic       m8_busy, m8_z, p8_z;
  int         m8_cnt, acc8;
  logic [7:0] m8_q, m8_r, p8_q, p8_r;

  always @(posedge clk or posedge rst8) begin
    if (rst8) begin
      m8_busy = 1'b0; m8_cnt = 0; m8_q = '0; m8_r = '0; m8_z = 1'b0;
    end else if (!m8_busy) begin
      if (sv8) begin
        m8_busy = 1'b1;
        acc8++;
        if (ds8 == 0) begin
          m8_cnt = 1; p8_q = 8'hFF; p8_r = dd8; p8_z = 1'b1;
        end else begin
          m8_cnt = 8; p8_q = dd8 / ds8; p8_r = dd8 % ds8; p8_z = 1'b0;
        end
      end
    end else if (m8_cnt > 0) begin
      m8_cnt--;
      if (m8_cnt == 0) begin
        m8_q = p8_q; m8_r = p8_r; m8_z = p8_z;
      end
    end else if (rr8) begin
      m8_busy = 1'b0;
    end
  end

  logic        m13_busy, m13_z, p13_z;
  int          m13_cnt, acc13;
  logic [12:0] m13_q, m13_r, p13_q, p13_r;

  always @(posedge clk or posedge rst13) begin
    if (rst13) begin
      m13_busy = 1'b0; m13_cnt = 0; m13_q = '0; m13_r = '0; m13_z = 1'b0;
    end else if (!m13_busy) begin
      if (sv13) begin
        m13_busy = 1'b1;
        acc13++;
        if (ds13 == 0) begin
          m13_cnt = 1; p13_q = 13'h1FFF; p13_r = dd13; p13_z = 1'b1;
        end else begin
          m13_cnt = 13; p13_q = dd13 / ds13; p13_r = dd13 % ds13; p13_z = 1'b0;
        end
      end
    end else if (m13_cnt > 0) begin
      m13_cnt--;
      if (m13_cnt == 0) begin
        m13_q = p13_q; m13_r = p13_r; m13_z = p13_z;
      end
    end else if (rr13) begin
      m13_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("w8_start_ready", int'(sr8), int'(!m8_busy));
    chk("w8_res_valid", int'(rv8), int'(m8_busy && m8_cnt == 0));
    chk("w8_quotient", int'(q8), int'(m8_q));
    chk("w8_remainder", int'(r8), int'(m8_r));
    chk("w8_div_by_zero", int'(z8), int'(m8_z));
    chk("w13_start_ready", int'(sr13), int'(!m13_busy));
    chk("w13_res_valid", int'(rv13), int'(m13_busy && m13_cnt == 0));
    chk("w13_quotient", int'(q13), int'(m13_q));
    chk("w13_remainder", int'(r13), int'(m13_r));
    chk("w13_div_by_zero", int'(z13), int'(m13_z));
  end

  // Directed request on the 8-bit instance with literal expectations; called at a negedge.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input int eq, input int er, input int ez, input int elat);
    int n;
    n = 0;
    while (!sr8 && n < 100) begin @(negedge clk); n++; end
    sv8 = 1'b1; dd8 = a; ds8 = b;
    @(negedge clk);
    sv8 = 1'b0;
    n = 0;
    while (!rv8 && n < 100) begin @(negedge clk); n++; end
    chk("lit_latency", n, elat);
    chk("lit_quotient", int'(q8), eq);
    chk("lit_remainder", int'(r8), er);
    chk("lit_div_by_zero", int'(z8), ez);
    @(negedge clk);
    chk("lit_valid_one_cycle", int'(rv8), 0);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; done8 = 1'b0; acc8 = 0;
    rst8 = 1'b0; sv8 = 1'b0; rr8 = 1'b1; dd8 = '0; ds8 = '0;
    #1 rst8 = 1'b1;
    @(negedge clk);
    chk("reset_start_ready", int'(sr8), 1);
    chk("reset_res_valid", int'(rv8), 0);
    chk("reset_quotient", int'(q8), 0);
    chk("reset_remainder", int'(r8), 0);
    chk("reset_div_by_zero", int'(z8), 0);
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);

    run8(8'd200, 8'd7, 28, 4, 0, 8);
    run8(8'd5, 8'd0, 255, 5, 1, 1);
    run8(8'd255, 8'd1, 255, 0, 0, 8);
    run8(8'd3, 8'd10, 0, 3, 0, 8);
    run8(8'd255, 8'd255, 1, 0, 0, 8);
    run8(8'd0, 8'd9, 0, 0, 0, 8);
    run8(8'd128, 8'd2, 64, 0, 0, 8);

    // Backpressure: result held while new requests are offered and refused.
    rr8 = 1'b0; sv8 = 1'b1; dd8 = 8'd100; ds8 = 8'd7;
    @(negedge clk);
    sv8 = 1'b0;
    n = 0;
    while (!rv8 && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(rv8), 1);
      chk("bp_start_ready", int'(sr8), 0);
      chk("bp_quotient", int'(q8), 14);
      chk("bp_remainder", int'(r8), 2);
      sv8 = 1'b1; dd8 = 8'd50; ds8 = 8'd5;
      @(negedge clk);
    end
    sv8 = 1'b0; rr8 = 1'b1;
    @(negedge clk);
    chk("bp_after_ready", int'(sr8), 1);
    chk("bp_after_valid", int'(rv8), 0);
    chk("bp_after_quotient", int'(q8), 14);
    chk("bp_after_remainder", int'(r8), 2);

    // Reset during the fourth iteration of 100/3.
    sv8 = 1'b1; dd8 = 8'd100; ds8 = 8'd3;
    @(negedge clk);
    sv8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk("abort_quotient", int'(q8), 0);
    chk("abort_remainder", int'(r8), 0);
    chk("abort_valid", int'(rv8), 0);
    chk("abort_ready", int'(sr8), 1);
    @(negedge clk);
    rst8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_valid", int'(rv8), 0);
    end
    run8(8'd100, 8'd3, 33, 1, 0, 8);

    acc8 = 0;
    n = 0;
    while (acc8 < 1000 && n < 60000) begin
      sv8 = 1'($urandom % 2);
      dd8 = 8'($urandom);
      ds8 = ($urandom % 10 == 0) ? 8'd0 : 8'($urandom);
      rr8 = ($urandom % 3 != 0);
      @(negedge clk);
      n++;
    end
    sv8 = 1'b0; rr8 = 1'b1;
    chk("w8_random_accepts", int'(acc8 >= 1000), 1);
    repeat (20) @(negedge clk);
    done8 = 1'b1;
  end

  initial begin
    int n;
    int sel;
    done13 = 1'b0; acc13 = 0;
    rst13 = 1'b0; sv13 = 1'b0; rr13 = 1'b1; dd13 = '0; ds13 = '0;
    #1 rst13 = 1'b1;
    repeat (2) @(negedge clk);
    rst13 = 1'b0;
    @(negedge clk);
    n = 0;
    while (acc13 < 1000 && n < 60000) begin
      sv13 = 1'($urandom % 2);
      dd13 = 13'($urandom);
      sel  = $urandom % 10;
      if (sel == 0)      ds13 = '0;
      else if (sel < 4)  ds13 = 13'($urandom_range(1, 15));
      else               ds13 = 13'($urandom);
      rr13 = ($urandom % 3 != 0);
      @(negedge clk);
      n++;
    end
    sv13 = 1'b0; rr13 = 1'b1;
    chk("w13_random_accepts", int'(acc13 >= 1000), 1);
    repeat (20) @(negedge clk);
    done13 = 1'b1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait (done8 === 1'b1 && done13 === 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
